// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, arbiter state encoding and width helper.
package uart_pkg;
    localparam int UART_BYTE_W = 8;
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LAUNCH    = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    typedef logic [UART_BYTE_W-1:0] uart_byte_t;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search starting just above ptr, wrapping modulo N.
module rr_pick
    import uart_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [clog2(N)-1:0]   ptr,
    output logic                  found,
    output logic [clog2(N)-1:0]   idx
);
    localparam int IW = clog2(N);
    int c;
    always_comb begin
        found = 1'b0;
        idx = '0;
        c = 0;
        // Scan from farthest to nearest so the nearest hit wins.
        for (int i = N; i >= 1; i--) begin
            c = int'(ptr) + i;
            c = (c >= N) ? c - N : c;
            if (req[IW'(c)]) begin
                found = 1'b1;
                idx = IW'(c);
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART TX engine between NUM_REQ byte producers.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LAUNCH_TIMEOUT = 15
) (
    input  logic                             i_SysClock,
    input  logic                             i_Reset,
    input  logic [NUM_REQ-1:0]               i_ReqValid,
    input  logic [NUM_REQ*UART_BYTE_W-1:0]   i_ReqByte,
    output logic [NUM_REQ-1:0]               o_ReqReady,
    output logic                             o_TxValid,
    output uart_byte_t                       o_TxByte,
    input  logic                             i_TxDone,
    output logic [clog2(NUM_REQ)-1:0]        o_GrantIdx,
    output logic                             o_Busy,
    output logic                             o_FrameDone,
    output logic                             o_Error
);
    localparam int IW = clog2(NUM_REQ);
    localparam int CW = clog2(LAUNCH_TIMEOUT + 1);
    localparam logic [NUM_REQ-1:0] REQ_ONE = 1;
    logic [1:0]    state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic [CW-1:0] cnt;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (i_ReqValid),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge i_SysClock) begin
        if (i_Reset) begin
            state <= ST_IDLE;
            ptr <= IW'(NUM_REQ - 1);
            cnt <= '0;
            o_ReqReady <= '0;
            o_TxValid <= 1'b0;
            o_TxByte <= '0;
            o_GrantIdx <= '0;
            o_Busy <= 1'b0;
            o_FrameDone <= 1'b0;
            o_Error <= 1'b0;
        end else begin
            o_ReqReady <= '0;
            o_FrameDone <= 1'b0;
            o_Error <= 1'b0;
            case (state)
                ST_IDLE: if (i_TxDone && pick_found) begin
                    state <= ST_LAUNCH;
                    ptr <= pick_idx;
                    o_GrantIdx <= pick_idx;
                    o_ReqReady <= REQ_ONE << pick_idx;
                    o_TxByte <= i_ReqByte[pick_idx*UART_BYTE_W +: UART_BYTE_W];
                    o_TxValid <= 1'b1;
                    o_Busy <= 1'b1;
                    cnt <= '0;
                end
                ST_LAUNCH: if (!i_TxDone) begin
                    state <= ST_WAIT_DONE;
                    o_TxValid <= 1'b0;
                    cnt <= '0;
                end else if (cnt == CW'(LAUNCH_TIMEOUT - 1)) begin
                    // Engine never started: drop the byte, keep the pointer on the loser.
                    state <= ST_IDLE;
                    o_TxValid <= 1'b0;
                    o_Busy <= 1'b0;
                    o_Error <= 1'b1;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                ST_WAIT_DONE: if (i_TxDone) begin
                    state <= ST_IDLE;
                    o_Busy <= 1'b0;
                    o_FrameDone <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    o_Busy <= 1'b0;
                    o_TxValid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one UART transmit engine between NUM_REQ byte producers (e.g. debug console, status reporter, command echo).
- Sits between the producers and the TX engine, which exposes a valid/byte input and a "done" output that is high only while the engine is idle.
- Accepts one byte per grant into a holding register, launches the frame, and tracks the engine until the frame completes.
- Reports a launch timeout if the engine never starts the frame.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LAUNCH_TIMEOUT, 15, maximum cycles in LAUNCH waiting for i_TxDone to fall before abort.

Ports:
- i_SysClock  input  1  system clock; all logic on its rising edge.
- i_Reset  input  1  synchronous, active-high reset.
- i_ReqValid  input  NUM_REQ  per-requester byte-valid; held until the matching o_ReqReady bit pulses.
- i_ReqByte  input  NUM_REQ*8  packed bytes; requester k uses bits [8k+7:8k].
- o_ReqReady  output  NUM_REQ  one-hot, one-cycle acknowledge; the byte was captured.
- o_TxValid  output  1  launch request to the TX engine.
- o_TxByte  output  8  byte to the TX engine.
- i_TxDone  input  1  engine idle flag from the TX engine.
- o_GrantIdx  output  $clog2(NUM_REQ)  index of the current/last granted requester.
- o_Busy  output  1  high in any state other than IDLE.
- o_FrameDone  output  1  one-cycle pulse when a granted frame completes.
- o_Error  output  1  one-cycle pulse on launch timeout.

Behaviour:
- Reset values:
  - state=IDLE.
  - o_ReqReady=0, o_TxValid=0, o_TxByte=8'h00.
  - o_GrantIdx=0, round-robin pointer=NUM_REQ-1, so requester 0 has first priority.
  - o_FrameDone=0, o_Error=0, timeout counter=0.
- All outputs are registered.
- States: IDLE, LAUNCH, WAIT_DONE.
- IDLE, at cycle t:
  - If i_TxDone=1 and |i_ReqValid, select the first valid requester searching upward from pointer+1, wrapping modulo NUM_REQ.
  - At edge t+1: o_ReqReady[k]=1 for one cycle, o_TxByte<=byte k, o_GrantIdx<=k, pointer<=k, o_TxValid<=1, go to LAUNCH.
  - If i_TxDone=0, no grant is made, even with requests pending.
- LAUNCH:
  - o_TxValid stays high and the counter increments each cycle.
  - On the first cycle i_TxDone=0: o_TxValid<=0, counter cleared, go to WAIT_DONE.
  - If the counter reaches LAUNCH_TIMEOUT with i_TxDone still 1: o_TxValid<=0, pulse o_Error, go to IDLE. The byte is dropped, not retried, and the pointer stays at k.
- WAIT_DONE:
  - On i_TxDone=1: pulse o_FrameDone and go to IDLE.
  - The next grant can occur in that first IDLE cycle (back-to-back frames).
- o_TxByte is held constant from grant until the next grant. The engine samples the byte throughout its start-bit period, so the value must not change mid-frame.
- Only the one-cycle o_ReqReady acknowledges a requester; no other requester sees ready while a frame is in flight.
- Simultaneous requests: exactly one grant per frame; the rotating pointer guarantees each persistent requester is served within NUM_REQ frames.
- A requester that deasserts valid before being granted is simply skipped; the arbiter does not require valid to be held after ready.
- Reset mid-frame returns to IDLE with reset values on the next edge. The TX engine shares the same reset, so no partial-frame state is retained.
- Pointer arithmetic wraps modulo NUM_REQ for non-power-of-two NUM_REQ.

Decomposition:
- Shared package uart_pkg:
  - state encoding constants (IDLE, LAUNCH, WAIT_DONE);
  - UART_BYTE_W=8;
  - a clog2 helper used by both TX and arbiter blocks.
- One natural sub-module: rr_pick. It is a combinational round-robin priority search taking request vector and pointer and returning a found flag and index. It is reusable by a future RX-side dispatcher.

Test Plan:
- Single request: i_ReqValid=4'b0100, byte 8'hA5 -> o_ReqReady=4'b0100 for one cycle, o_TxByte=8'hA5, o_GrantIdx=2, o_TxValid high until i_TxDone falls, then o_FrameDone pulses once when i_TxDone returns high.
- All four requesting continuously with bytes 8'h10..8'h13 -> grant order 0,1,2,3,0 across five frames; o_TxByte stays stable for each full frame.
- Engine busy: i_TxDone held 0, request on 1 -> no o_ReqReady. Release i_TxDone -> grant on the next cycle.
- Timeout: model never drops i_TxDone after launch -> o_Error pulses exactly LAUNCH_TIMEOUT cycles after entering LAUNCH; state returns to IDLE; requester 3's next request is still served.
- Reset mid-WAIT_DONE: assert i_Reset one cycle -> o_Busy=0, o_TxValid=0, o_TxByte=8'h00, next grant goes to the lowest valid index.
- Back-to-back frames: requests 0 and 1 pending -> second grant occurs on the cycle after o_FrameDone, with no idle gap beyond one cycle.
